// File: rtl/pc_trace_pkg.sv
// pc_trace_pkg: shared FSM state encoding and default sizing for the PC trace
// buffer and its breakpoint comparator.
package pc_trace_pkg;

    typedef enum logic [1:0] {
        ARMED   = 2'b00,
        STOPPED = 2'b01,
        HALTED  = 2'b10
    } trace_state_e;

    localparam int DEF_PC_W   = 9;
    localparam int DEF_DEPTH  = 16;
    localparam int DEF_NUM_BP = 2;

    // Selector width for n comparators; a single comparator still gets a 1-bit select.
    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pc_bp_compare.sv
// pc_bp_compare: NUM_BP breakpoint address/valid registers and a combinational
// "PC matches any armed breakpoint" output. A write becomes visible to the
// compare from the edge after it is loaded.
module pc_bp_compare
    import pc_trace_pkg::*;
#(
    parameter int PC_W   = DEF_PC_W,
    parameter int NUM_BP = DEF_NUM_BP,
    parameter int SEL_W  = sel_width(NUM_BP)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             bp_wr,
    input  logic [SEL_W-1:0] bp_sel,
    input  logic [PC_W-1:0]  bp_addr,
    input  logic             bp_valid,
    input  logic [PC_W-1:0]  cmp_pc,
    output logic             match
);

    logic [PC_W-1:0]   r_addr [NUM_BP];
    logic [NUM_BP-1:0] r_valid;

    // Valid bits are cleared by reset so no stale address can fire after power-up.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid <= '0;
        end else if (bp_wr && (int'(bp_sel) < NUM_BP)) begin
            r_valid[bp_sel] <= bp_valid;
        end
    end

    // Addresses are only meaningful behind a valid bit, so they carry no reset.
    always_ff @(posedge clk) begin
        if (bp_wr && (int'(bp_sel) < NUM_BP)) begin
            r_addr[bp_sel] <= bp_addr;
        end
    end

    // Any armed comparator equal to the presented PC raises match.
    always_comb begin
        match = 1'b0;
        for (int i = 0; i < NUM_BP; i++) begin
            if (r_valid[i] && (r_addr[i] == cmp_pc)) begin
                match = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pc_trace_buffer.sv
// pc_trace_buffer: circular trace of fetched PCs with show-ahead read port,
// breakpoint stop and CPU-halt freeze.
// Build option: define TRACE_OVERWRITE_EN to let a capture into a full buffer
// evict the oldest entry; by default such a capture is dropped. Either way the
// sticky overflow flag is raised.
module pc_trace_buffer
    import pc_trace_pkg::*;
#(
    parameter int PC_W   = DEF_PC_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int NUM_BP = DEF_NUM_BP
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         if1_pulse,
    input  logic [PC_W-1:0]              pc,
    input  logic                         halted,
    input  logic                         clear,
    input  logic                         rd_en,
    input  logic                         bp_wr,
    input  logic [sel_width(NUM_BP)-1:0] bp_sel,
    input  logic [PC_W-1:0]              bp_addr,
    input  logic                         bp_valid,
    output logic [PC_W-1:0]              rd_data,
    output logic [$clog2(DEPTH):0]       count,
    output logic                         empty,
    output logic                         full,
    output logic                         overflow,
    output logic                         bp_hit,
    output logic                         stop_req
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    trace_state_e     r_state;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             r_overflow;
    logic             r_bp_hit;
    logic [PC_W-1:0]  r_mem [DEPTH];

    logic w_capture;
    logic w_pop;
    logic w_store;
    logic w_evict;
    logic w_ovf_set;
    logic w_bp_match;

    pc_bp_compare #(
        .PC_W   (PC_W),
        .NUM_BP (NUM_BP)
    ) u_bp (
        .clk      (clk),
        .reset    (reset),
        .bp_wr    (bp_wr),
        .bp_sel   (bp_sel),
        .bp_addr  (bp_addr),
        .bp_valid (bp_valid),
        .cmp_pc   (pc),
        .match    (w_bp_match)
    );

    assign empty    = (r_count == '0);
    assign full     = (r_count == CNT_W'(DEPTH));
    assign count    = r_count;
    assign overflow = r_overflow;
    assign bp_hit   = r_bp_hit;
    assign stop_req = (r_state == STOPPED);
    assign rd_data  = empty ? '0 : r_mem[r_rd_ptr];

    // Clear outranks everything. A pop on an empty buffer is ignored, so a
    // capture+pop on an empty buffer still leaves one entry behind.
    assign w_capture = if1_pulse && (r_state == ARMED) && !clear;
    assign w_pop     = rd_en && !empty && !clear;
    // A pop on the same edge makes room, so only an unmatched full capture overflows.
    assign w_ovf_set = w_capture && full && !w_pop;

`ifdef TRACE_OVERWRITE_EN
    assign w_store = w_capture;
    assign w_evict = w_ovf_set;
`else
    assign w_store = w_capture && (!full || w_pop);
    assign w_evict = 1'b0;
`endif

    // Pointer, occupancy and flag bookkeeping; an eviction retires the oldest entry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_bp_hit   <= 1'b0;
        end else if (clear) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_bp_hit   <= 1'b0;
        end else begin
            if (w_store) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop || w_evict) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count    <= r_count + CNT_W'(w_store) - CNT_W'(w_pop || w_evict);
            r_overflow <= r_overflow || w_ovf_set;
            r_bp_hit   <= w_capture && w_bp_match;
        end
    end

    // Trace storage needs no reset: unoccupied slots are never presented.
    always_ff @(posedge clk) begin
        if (w_store) begin
            r_mem[r_wr_ptr] <= pc;
        end
    end

    // Capture FSM: a breakpoint match stops tracing, a CPU halt freezes it; halt wins.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ARMED;
        end else if (clear) begin
            r_state <= ARMED;
        end else begin
            case (r_state)
                ARMED: begin
                    if (halted) begin
                        r_state <= HALTED;
                    end else if (w_capture && w_bp_match) begin
                        r_state <= STOPPED;
                    end
                end
                STOPPED: begin
                    if (halted) begin
                        r_state <= HALTED;
                    end
                end
                HALTED:  r_state <= HALTED;
                default: r_state <= ARMED;
            endcase
        end
    end

endmodule

// File: tb/tb_pc_trace_buffer.sv
// tb_pc_trace_buffer: directed scenarios followed by random traffic; a
// queue-based reference model predicts the state after each clock edge and a
// separate monitor compares the DUT against those predictions mid-cycle.
`timescale 1ns/1ps
module tb_pc_trace_buffer;

    localparam int PC_W   = 9;
    localparam int DEPTH  = 4;
    localparam int NUM_BP = 2;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             if1_pulse = 1'b0;
    logic [PC_W-1:0]  pc = '0;
    logic             halted = 1'b0;
    logic             clear = 1'b0;
    logic             rd_en = 1'b0;
    logic             bp_wr = 1'b0;
    logic [0:0]       bp_sel = '0;
    logic [PC_W-1:0]  bp_addr = '0;
    logic             bp_valid = 1'b0;
    logic [PC_W-1:0]  rd_data;
    logic [2:0]       count;
    logic             empty;
    logic             full;
    logic             overflow;
    logic             bp_hit;
    logic             stop_req;

    pc_trace_buffer #(.PC_W(PC_W), .DEPTH(DEPTH), .NUM_BP(NUM_BP)) dut (
        .clk(clk), .reset(reset), .if1_pulse(if1_pulse), .pc(pc),
        .halted(halted), .clear(clear), .rd_en(rd_en),
        .bp_wr(bp_wr), .bp_sel(bp_sel), .bp_addr(bp_addr), .bp_valid(bp_valid),
        .rd_data(rd_data), .count(count), .empty(empty), .full(full),
        .overflow(overflow), .bp_hit(bp_hit), .stop_req(stop_req)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cnt;
        int emp;
        int ful;
        int ovf;
        int stp;
        int hit;
        int rdd;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    // Reference model: the trace is simply a queue of PCs, oldest first.
    int       m_trace[$];
    bit       m_ovf, m_hit, m_stopped, m_halted;
    bit [8:0] m_bp_addr [NUM_BP];
    bit       m_bp_v    [NUM_BP];

    task automatic chk(input string name, input int act, input int expv);
        n_cmp++;
        if (act != expv) begin
            n_err++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, expv);
        end
    endtask

    task automatic model_edge(input bit rst_i, input bit if1, input int pc_i,
                              input bit hlt, input bit clr, input bit rd,
                              input bit bw, input int bsel, input int baddr, input bit bval);
        bit armed, popping, capture, match;
        exp_t e;
        if (rst_i) begin
            m_trace.delete();
            m_ovf = 0; m_hit = 0; m_stopped = 0; m_halted = 0;
            for (int i = 0; i < NUM_BP; i++) m_bp_v[i] = 0;
        end else begin
            if (clr) begin
                m_trace.delete();
                m_ovf = 0; m_hit = 0; m_stopped = 0; m_halted = 0;
            end else begin
                armed   = !m_stopped && !m_halted;
                popping = rd && (m_trace.size() > 0);
                capture = if1 && armed;
                match   = 0;
                for (int i = 0; i < NUM_BP; i++)
                    if (capture && m_bp_v[i] && (int'(m_bp_addr[i]) == pc_i)) match = 1;
                if (popping) void'(m_trace.pop_front());
                if (capture) begin
                    if (m_trace.size() < DEPTH) begin
                        m_trace.push_back(pc_i);
                    end else begin
                        m_ovf = 1;
`ifdef TRACE_OVERWRITE_EN
                        void'(m_trace.pop_front());
                        m_trace.push_back(pc_i);
`endif
                    end
                end
                m_hit = match;
                if (hlt) begin
                    m_halted = 1; m_stopped = 0;
                end else if (match) begin
                    m_stopped = 1;
                end
            end
            if (bw) begin
                m_bp_addr[bsel] = 9'(baddr);
                m_bp_v[bsel]    = bval;
            end
        end
        e.cnt = m_trace.size();
        e.emp = (m_trace.size() == 0);
        e.ful = (m_trace.size() == DEPTH);
        e.ovf = m_ovf;
        e.stp = m_stopped;
        e.hit = m_hit;
        e.rdd = (m_trace.size() > 0) ? m_trace[0] : 0;
        exp_q.push_back(e);
    endtask

    // One clock of stimulus: drive after the falling edge, predict at the rising edge.
    task automatic step(input bit rst_i, input bit if1, input int pc_i, input bit hlt,
                        input bit clr, input bit rd, input bit bw, input int bsel,
                        input int baddr, input bit bval);
        @(negedge clk);
        #1;
        reset = rst_i; if1_pulse = if1; pc = 9'(pc_i); halted = hlt; clear = clr;
        rd_en = rd; bp_wr = bw; bp_sel = 1'(bsel); bp_addr = 9'(baddr); bp_valid = bval;
        @(posedge clk);
        model_edge(rst_i, if1, pc_i, hlt, clr, rd, bw, bsel, baddr, bval);
    endtask

    task automatic cap(input int p);  step(0, 1, p, 0, 0, 0, 0, 0, 0, 0); endtask
    task automatic pop();             step(0, 0, 0, 0, 0, 1, 0, 0, 0, 0); endtask
    task automatic idle();            step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); endtask
    task automatic clr();             step(0, 0, 0, 0, 1, 0, 0, 0, 0, 0); endtask
    task automatic bpw(input int s, input int a, input bit v);
        step(0, 0, 0, 0, 0, 0, 1, s, a, v);
    endtask

    // Monitor: every mid-cycle, compare the DUT against the oldest prediction.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("count",    int'(count),    e.cnt);
            chk("empty",    int'(empty),    e.emp);
            chk("full",     int'(full),     e.ful);
            chk("overflow", int'(overflow), e.ovf);
            chk("stop_req", int'(stop_req), e.stp);
            chk("bp_hit",   int'(bp_hit),   e.hit);
            chk("rd_data",  int'(rd_data),  e.rdd);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held for two edges, then released.
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 1, 7, 0, 0, 1, 0, 0, 0, 0);
        idle();

        // Three captures drained in order.
        cap(0); cap(1); cap(2);
        pop(); pop(); pop(); pop();
        clr();

        // Capture into a full buffer: dropped or evicting depending on build.
        for (int i = 0; i < 5; i++) cap(i);
        for (int i = 0; i < 4; i++) pop();
        clr();

        // Full buffer with capture and pop together: no overflow, count unchanged.
        for (int i = 0; i < 4; i++) cap(i);
        step(0, 1, 7, 0, 0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) pop();
        clr();

        // Breakpoint at 5 stops the trace after storing 5.
        bpw(0, 5, 1);
        cap(3); cap(4); cap(5); cap(6); idle();
        pop(); pop(); pop();
        clr();

        // Halt freezes capture; clear re-arms and keeps the breakpoint.
        cap(1); cap(2);
        step(0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        idle(); cap(8); pop();
        clr();
        cap(5); idle();
        clr();

        // Capture coinciding with halt is still stored.
        step(0, 1, 9, 1, 0, 0, 0, 0, 0, 0);
        idle(); pop();
        clr();

        // A breakpoint written on the capture edge does not fire until the next edge.
        step(0, 1, 6, 0, 0, 0, 1, 1, 6, 1);
        cap(6); idle();
        clr();

        // Disabled breakpoint, then clear colliding with capture, pop and halt.
        bpw(0, 5, 0);
        cap(5); cap(2);
        step(0, 1, 3, 1, 1, 1, 0, 0, 0, 0);
        idle();

        // Reset arriving together with a capture discards it.
        cap(1);
        step(1, 1, 3, 0, 0, 0, 0, 0, 0, 0);
        idle();

        // Random traffic.
        for (int n = 0; n < 3000; n++) begin
            bit r_rst, r_if1, r_hlt, r_clr, r_rd, r_bw, r_bv;
            int r_pc, r_sel, r_ba;
            r_rst = ($urandom_range(0, 199) == 0);
            r_if1 = ($urandom_range(0, 1) == 1);
            r_pc  = $urandom_range(0, 15);
            r_hlt = ($urandom_range(0, 49) == 0);
            r_clr = ($urandom_range(0, 29) == 0);
            r_rd  = ($urandom_range(0, 9) < 4);
            r_bw  = ($urandom_range(0, 19) == 0);
            r_sel = $urandom_range(0, 1);
            r_ba  = $urandom_range(0, 15);
            r_bv  = ($urandom_range(0, 3) != 0);
            step(r_rst, r_if1, r_pc, r_hlt, r_clr, r_rd, r_bw, r_sel, r_ba, r_bv);
        end
        idle();

        repeat (3) @(negedge clk);
        #1;
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pc_trace_buffer.md
PC_TRACE_BUFFER -- requirements
Module: pc_trace_buffer

Interface
REQ-001 SHALL have parameter PC_W, default 9, PC width in bits.
REQ-002 SHALL have parameter DEPTH, default 16, trace entries; power of two, >= 2.
REQ-003 SHALL have parameter NUM_BP, default 2, breakpoint comparator count, >= 1.
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port if1_pulse  input  1  high one cycle when CPU FSM enters IF1.
REQ-007 SHALL have port pc  input  PC_W  CPU PC, valid while if1_pulse is high.
REQ-008 SHALL have port halted  input  1  CPU HALT reached (drives LEDR[8] at top).
REQ-009 SHALL have port clear  input  1  synchronous flush of the trace and resume.
REQ-010 SHALL have port rd_en  input  1  pop the oldest entry.
REQ-011 SHALL have ports bp_wr  input  1, bp_sel  input  clog2(NUM_BP), bp_addr  input  PC_W, bp_valid  input  1  breakpoint register write.
REQ-012 SHALL have port rd_data  output  PC_W  oldest entry, show-ahead.
REQ-013 SHALL have ports count  output  clog2(DEPTH)+1, empty  output  1, full  output  1.
REQ-014 SHALL have ports overflow  output  1 (sticky), bp_hit  output  1 (one-cycle pulse), stop_req  output  1 (sticky CPU stall request).

Function
REQ-015 SHALL run a 3-state FSM: ARMED (capturing), STOPPED (breakpoint), HALTED (CPU halt); captures occur only in ARMED.
REQ-016 In ARMED, a rising edge with if1_pulse=1 SHALL write pc at wr_ptr, advance wr_ptr modulo DEPTH, and increment count.
REQ-017 SHALL present rd_data combinationally from rd_ptr; rd_en with empty=1 SHALL be ignored, with rd_data holding its value.
REQ-018 A simultaneous capture and pop SHALL leave count unchanged, in all states of fill.
REQ-019 empty SHALL equal (count==0); full SHALL equal (count==DEPTH).
REQ-020 A capture while full SHALL follow REQ-032, and SHALL set overflow in both configurations.
REQ-021 A capture whose pc equals any bp_addr with valid bit set SHALL still be stored, SHALL assert bp_hit on the following cycle, and SHALL move ARMED->STOPPED.
REQ-022 stop_req SHALL be 1 exactly while the state is STOPPED.
REQ-023 halted=1 SHALL move ARMED or STOPPED to HALTED on the next edge; a capture on that same edge SHALL still be stored.
REQ-024 clear=1 SHALL zero the pointers, count and overflow, and SHALL return the FSM to ARMED. It SHALL take priority over capture, pop and halted on the same edge, and SHALL leave the breakpoint registers intact.
REQ-025 bp_wr SHALL load bp_addr/bp_valid into entry bp_sel; the new value SHALL apply to compares from the next edge.
REQ-026 Pops SHALL remain allowed in STOPPED and HALTED.

Reset
REQ-027 reset=1 SHALL immediately set the pointers, count, overflow, bp_hit and all breakpoint valid bits to 0, and the FSM to ARMED.
REQ-028 During reset: empty=1, full=0, stop_req=0, rd_data=0.
REQ-029 Storage contents SHALL NOT need reset; rd_data SHALL be forced to 0 while empty.
REQ-030 A reset asserted mid-capture SHALL discard that capture.

Configuration
REQ-031 Macro TRACE_OVERWRITE_EN SHALL select the full-buffer policy.
REQ-032 Defined: a capture while full SHALL overwrite the oldest entry and advance rd_ptr, with count staying DEPTH. Undefined: a capture while full SHALL be dropped, with the pointers unchanged.

Structure
REQ-033 A shared package pc_trace_pkg SHALL hold the FSM state encoding (ARMED=2'b00, STOPPED=2'b01, HALTED=2'b10) and the default PC_W, DEPTH and NUM_BP.
REQ-034 Breakpoint registers and match logic SHALL live in one sub-module, pc_bp_compare, which outputs a combinational match.

Verification (DEPTH=4, PC_W=9, NUM_BP=2)
REQ-035 Capture PCs 0,1,2 then pop three times -> rd_data 0,1,2, and empty=1 after the last pop.
REQ-036 Capture 0..4 with the macro undefined -> overflow=1, count=4, pops return 0,1,2,3.
REQ-037 Capture 0..4 with TRACE_OVERWRITE_EN defined -> overflow=1, pops return 1,2,3,4.
REQ-038 bp0=9'h005 valid, capture 3,4,5,6 -> 5 stored, bp_hit one cycle after, stop_req=1, 6 not stored, count=3.
REQ-039 Pulse halted with count=2, then capture -> count stays 2; clear -> count=0, state ARMED, bp0 still valid.
REQ-040 Full buffer with capture and rd_en on the same edge -> count stays 4, overflow stays 0.
